// File: rtl/wb_arbiter2.sv
// Two-master / one-slave classic Wishbone arbiter with round-robin grant, whole-cycle
// grant hold and a strobe watchdog that turns a never-acked access into an error.
module wb_arbiter2 #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_data_i,
  output logic [DW-1:0] m0_data_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_data_i,
  output logic [DW-1:0] m1_data_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_addr_o,
  output logic [DW-1:0] s_data_o,
  input  logic [DW-1:0] s_data_i,
  input  logic          s_ack_i,
  output logic [1:0]    grant_o,
  output logic          timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OWN0,
    S_OWN1,
    S_RELEASE
  } state_t;

  state_t        r_state;
  logic          r_last_winner;
  logic [CW-1:0] r_wd_cnt;
  logic          r_timeout;

  logic w_own0;
  logic w_own1;
  logic w_cyc;
  logic w_stb;
  logic w_timeout;
  logic w_rel_cyc;

  assign w_own0 = (r_state == S_OWN0);
  assign w_own1 = (r_state == S_OWN1);

  // NOTE: forwarding is combinational so a master dropping cyc is seen by the slave
  // in the same cycle; only the ownership decision itself is registered.
  assign w_cyc = w_own0 ? m0_cyc_i : (w_own1 ? m1_cyc_i : 1'b0);
  assign w_stb = w_own0 ? m0_stb_i : (w_own1 ? m1_stb_i : 1'b0);

  // An ack arriving in the would-be timeout cycle wins over the error.
  assign w_timeout = (w_own0 | w_own1) & w_stb & ~s_ack_i
                   & (r_wd_cnt == CW'(TIMEOUT - 1));

  // In RELEASE the stalled owner is the one recorded as last winner.
  assign w_rel_cyc = r_last_winner ? m1_cyc_i : m0_cyc_i;

  assign s_cyc_o  = w_cyc;
  assign s_stb_o  = w_stb;
  assign s_we_o   = w_own0 ? m0_we_i   : (w_own1 ? m1_we_i   : 1'b0);
  assign s_addr_o = w_own0 ? m0_addr_i : (w_own1 ? m1_addr_i : '0);
  assign s_data_o = w_own0 ? m0_data_i : (w_own1 ? m1_data_i : '0);

  assign m0_ack_o  = w_own0 & s_ack_i & ~w_timeout;
  assign m1_ack_o  = w_own1 & s_ack_i & ~w_timeout;
  assign m0_err_o  = w_own0 & w_timeout;
  assign m1_err_o  = w_own1 & w_timeout;
  assign m0_data_o = w_own0 ? s_data_i : '0;
  assign m1_data_o = w_own1 ? s_data_i : '0;

  // RELEASE reports no owner: the slave port is parked while the stalled master lets go.
  assign grant_o   = {w_own1, w_own0};
  assign timeout_o = r_timeout;

  // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_last_winner <= 1'b1;
      r_wd_cnt      <= '0;
      r_timeout     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wd_cnt <= '0;
          if (m0_cyc_i && m1_cyc_i) begin
            r_state <= r_last_winner ? S_OWN0 : S_OWN1;
          end else if (m0_cyc_i) begin
            r_state <= S_OWN0;
          end else if (m1_cyc_i) begin
            r_state <= S_OWN1;
          end
        end
        S_OWN0, S_OWN1: begin
          if (!w_cyc) begin
            r_state       <= S_IDLE;
            r_last_winner <= w_own1;
            r_wd_cnt      <= '0;
          end else if (w_timeout) begin
            r_state       <= S_RELEASE;
            r_last_winner <= w_own1;
            r_timeout     <= 1'b1;
            r_wd_cnt      <= '0;
          end else if (w_stb && !s_ack_i) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end else begin
            r_wd_cnt <= '0;
          end
        end
        default: begin
          r_wd_cnt <= '0;
          if (!w_rel_cyc) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: directed scenarios followed by random master/slave traffic,
// all compared every cycle against a transaction-level ownership model.
module tb_wb_arbiter2;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          m0_cyc_i = 1'b0, m0_stb_i = 1'b0, m0_we_i = 1'b0;
  logic [AW-1:0] m0_addr_i = '0;
  logic [DW-1:0] m0_data_i = '0;
  logic [DW-1:0] m0_data_o;
  logic          m0_ack_o, m0_err_o;
  logic          m1_cyc_i = 1'b0, m1_stb_i = 1'b0, m1_we_i = 1'b0;
  logic [AW-1:0] m1_addr_i = '0;
  logic [DW-1:0] m1_data_i = '0;
  logic [DW-1:0] m1_data_o;
  logic          m1_ack_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_addr_o;
  logic [DW-1:0] s_data_o;
  logic [DW-1:0] s_data_i = '0;
  logic          s_ack_i = 1'b0;
  logic [1:0]    grant_o;
  logic          timeout_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who owns the bus, whether it is parked after a timeout,
  // who won last, how many consecutive unacked strobes, and the sticky flag.
  int md_owner  = -1;
  bit md_hold   = 1'b0;
  int md_last   = 1;
  int md_wait   = 0;
  bit md_sticky = 1'b0;

  wb_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT(TO), .CW(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i),
    .s_ack_i(s_ack_i), .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic m0_set(input bit c, input bit s, input bit w, input logic [31:0] a,
                        input logic [31:0] d);
    m0_cyc_i = c; m0_stb_i = s; m0_we_i = w; m0_addr_i = a; m0_data_i = d;
  endtask

  task automatic m1_set(input bit c, input bit s, input bit w, input logic [31:0] a,
                        input logic [31:0] d);
    m1_cyc_i = c; m1_stb_i = s; m1_we_i = w; m1_addr_i = a; m1_data_i = d;
  endtask

  task automatic slv_set(input bit ack, input logic [31:0] d);
    s_ack_i = ack; s_data_i = d;
  endtask

  function automatic bit mdl_owned();
    return (md_owner >= 0) && !md_hold;
  endfunction

  function automatic bit mdl_cyc();
    return (md_owner == 0) ? m0_cyc_i : m1_cyc_i;
  endfunction

  function automatic bit mdl_stb();
    return (md_owner == 0) ? m0_stb_i : m1_stb_i;
  endfunction

  function automatic bit mdl_to();
    return mdl_owned() && mdl_stb() && !s_ack_i && (md_wait == TO - 1);
  endfunction

  task automatic model_reset();
    md_owner = -1; md_hold = 1'b0; md_last = 1; md_wait = 0; md_sticky = 1'b0;
  endtask

  task automatic model_check();
    bit own = mdl_owned();
    bit to  = mdl_to();
    bit o0  = own && (md_owner == 0);
    bit o1  = own && (md_owner == 1);
    check("grant",   grant_o,   {o1, o0});
    check("s_cyc",   s_cyc_o,   own && mdl_cyc());
    check("s_stb",   s_stb_o,   own && mdl_stb());
    check("s_we",    s_we_o,    o0 ? m0_we_i : (o1 ? m1_we_i : 1'b0));
    check("s_addr",  s_addr_o,  o0 ? m0_addr_i : (o1 ? m1_addr_i : 32'h0));
    check("s_data",  s_data_o,  o0 ? m0_data_i : (o1 ? m1_data_i : 32'h0));
    check("m0_ack",  m0_ack_o,  o0 && s_ack_i && !to);
    check("m0_err",  m0_err_o,  o0 && to);
    check("m0_data", m0_data_o, o0 ? s_data_i : 32'h0);
    check("m1_ack",  m1_ack_o,  o1 && s_ack_i && !to);
    check("m1_err",  m1_err_o,  o1 && to);
    check("m1_data", m1_data_o, o1 ? s_data_i : 32'h0);
    check("timeout", timeout_o, md_sticky);
  endtask

  task automatic model_update();
    bit to = mdl_to();
    if (md_owner < 0) begin
      md_wait = 0;
      if (m0_cyc_i && m1_cyc_i) md_owner = 1 - md_last;
      else if (m0_cyc_i)        md_owner = 0;
      else if (m1_cyc_i)        md_owner = 1;
    end else if (md_hold) begin
      if (!mdl_cyc()) begin
        md_owner = -1; md_hold = 1'b0;
      end
    end else if (!mdl_cyc()) begin
      md_last = md_owner; md_owner = -1;
    end else if (to) begin
      md_hold = 1'b1; md_last = md_owner; md_sticky = 1'b1;
    end else begin
      md_wait = (mdl_stb() && !s_ack_i) ? md_wait + 1 : 0;
    end
  endtask

  // One bus cycle: check outputs mid-cycle, then advance model and DUT together.
  task automatic tick();
    @(negedge clock);
    model_check();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic apply_reset();
    m0_set(0, 0, 0, 0, 0); m1_set(0, 0, 0, 0, 0); slv_set(0, 0);
    @(negedge clock);
    reset_n = 1'b0;
    #2;
    check("rst_grant", grant_o, 2'b00);
    check("rst_s_cyc", s_cyc_o, 1'b0);
    check("rst_tmo",   timeout_o, 1'b0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit: observed running expected finished");
    $fatal(1);
  end

  initial begin
    int  done0, done1, seq_i;
    bit  acked0, acked1, prev_stb, prev_ack;
    logic [1:0] prev_g;

    #3;
    check("por_grant", grant_o, 2'b00);
    check("por_s_stb", s_stb_o, 1'b0);
    check("por_acks",  {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 4'b0);
    apply_reset();

    // Single read from m0.
    m0_set(1, 1, 0, 32'h10, 0);
    tick();
    #1;
    check("rd_s_cyc", {s_cyc_o, s_stb_o}, 2'b11);
    check("rd_addr", s_addr_o, 32'h10);
    check("rd_grant1", grant_o, 2'b01);
    tick();
    slv_set(1, 32'hA5);
    #1;
    check("rd_ack", m0_ack_o, 1'b1);
    check("rd_data", m0_data_o, 32'hA5);
    check("rd_m1", {m1_ack_o, m1_err_o, m1_data_o}, 34'h0);
    check("rd_grant2", grant_o, 2'b01);
    tick();
    m0_set(0, 0, 0, 0, 0); slv_set(0, 0);
    tick();
    tick();

    // Contention: both keep requesting one-strobe cycles; slave acks a cycle later.
    apply_reset();
    done0 = 0; done1 = 0; seq_i = 0;
    acked0 = 0; acked1 = 0; prev_stb = 0; prev_ack = 0; prev_g = 2'b00;
    for (int c = 0; c < 48 && (done0 < 4 || done1 < 4); c++) begin
      m0_set(done0 < 4 && !acked0, done0 < 4 && !acked0, 1, 32'h100 + done0, 32'h5000 + c);
      m1_set(done1 < 4 && !acked1, done1 < 4 && !acked1, 0, 32'h200 + done1, 32'h6000 + c);
      slv_set(prev_stb && !prev_ack, 32'hC000 + c);
      #1;
      if (grant_o != 2'b00 && prev_g == 2'b00) begin
        check("rr_order", grant_o, (seq_i % 2 == 0) ? 2'b01 : 2'b10);
        seq_i++;
      end
      if (grant_o != 2'b00 && prev_g != 2'b00) check("rr_no_switch", grant_o, prev_g);
      acked0 = m0_ack_o; acked1 = m1_ack_o;
      done0 += int'(m0_ack_o); done1 += int'(m1_ack_o);
      prev_stb = s_stb_o; prev_ack = s_ack_i; prev_g = grant_o;
      tick();
    end
    check("rr_done0", done0, 4);
    check("rr_done1", done1, 4);
    m0_set(0, 0, 0, 0, 0); m1_set(0, 0, 0, 0, 0); slv_set(0, 0);
    tick();
    tick();

    // Held grant: m1 runs three strobes in one cycle while m0 waits.
    m1_set(1, 1, 1, 32'hA1, 32'h11);
    tick();
    m0_set(1, 1, 0, 32'hB0, 0); slv_set(1, 32'hD1);
    #1;
    check("hold_ack1", {m1_ack_o, m0_ack_o}, 2'b10);
    check("hold_grant", grant_o, 2'b10);
    tick();
    m1_set(1, 0, 1, 32'hA1, 32'h11); slv_set(0, 0);
    tick();
    m1_set(1, 1, 1, 32'hA2, 32'h22); slv_set(1, 32'hD2);
    #1;
    check("hold_addr2", s_addr_o, 32'hA2);
    check("hold_ack2", {m1_ack_o, m0_ack_o}, 2'b10);
    tick();
    m1_set(1, 1, 0, 32'hA3, 32'h33); slv_set(1, 32'hD3);
    #1;
    check("hold_ack3", {m1_ack_o, m0_ack_o, s_we_o}, 3'b100);
    tick();
    m1_set(0, 0, 0, 0, 0); slv_set(0, 0);
    #1;
    check("hold_still_m1", grant_o, 2'b10);
    tick();
    #1;
    check("hold_gap", grant_o, 2'b00);
    tick();
    #1;
    check("hold_m0_grant", grant_o, 2'b01);
    check("hold_m0_addr", s_addr_o, 32'hB0);
    slv_set(1, 32'hE0);
    tick();
    m0_set(0, 0, 0, 0, 0); slv_set(0, 0);
    tick();
    tick();

    // Ack lands in the would-be timeout cycle: the ack wins.
    m0_set(1, 1, 0, 32'h40, 0);
    tick();
    for (int c = 1; c <= TO; c++) begin
      slv_set(c == TO, 32'h77);
      #1;
      if (c == TO) begin
        check("ack_to_ack", m0_ack_o, 1'b1);
        check("ack_to_err", m0_err_o, 1'b0);
      end
      tick();
    end
    m0_set(0, 0, 0, 0, 0); slv_set(0, 0);
    tick();
    #1;
    check("ack_to_flag", timeout_o, 1'b0);
    tick();

    // Timeout: slave never acks m0.
    m0_set(1, 1, 0, 32'h50, 0);
    tick();
    for (int c = 1; c <= TO; c++) begin
      #1;
      check("to_err", m0_err_o, c == TO);
      if (c == TO) check("to_ack", m0_ack_o, 1'b0);
      tick();
    end
    m0_set(1, 0, 0, 32'h50, 0); m1_set(1, 1, 0, 32'h60, 0);
    #1;
    check("to_s_cyc", s_cyc_o, 1'b0);
    check("to_flag", timeout_o, 1'b1);
    check("to_grant", grant_o, 2'b00);
    tick();
    slv_set(1, 32'h99);
    #1;
    check("stray_ack", {m0_ack_o, m1_ack_o}, 2'b00);
    tick();
    slv_set(0, 0);
    tick();
    m0_set(0, 0, 0, 0, 0);
    tick();
    #1;
    check("to_idle", grant_o, 2'b00);
    tick();
    #1;
    check("to_m1_grant", grant_o, 2'b10);
    tick();
    m1_set(0, 0, 0, 0, 0);
    tick();
    tick();

    // Asynchronous reset in the middle of an m0 access.
    m0_set(1, 1, 1, 32'h70, 32'h7);
    tick();
    tick();
    #1;
    reset_n = 1'b0;
    #1;
    check("amid_s_cyc", s_cyc_o, 1'b0);
    check("amid_grant", grant_o, 2'b00);
    check("amid_tmo", timeout_o, 1'b0);
    model_reset();
    m1_set(1, 1, 0, 32'h80, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    model_update();
    #1;
    check("amid_tie_m0", grant_o, 2'b01);
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      if (!m0_cyc_i) m0_cyc_i = ($urandom % 3 == 0);
      else if ($urandom % 6 == 0) m0_cyc_i = 1'b0;
      if (!m1_cyc_i) m1_cyc_i = ($urandom % 3 == 0);
      else if ($urandom % 6 == 0) m1_cyc_i = 1'b0;
      m0_stb_i  = m0_cyc_i && ($urandom % 4 != 0);
      m1_stb_i  = m1_cyc_i && ($urandom % 4 != 0);
      m0_we_i   = 1'($urandom);
      m1_we_i   = 1'($urandom);
      m0_addr_i = $urandom; m0_data_i = $urandom;
      m1_addr_i = $urandom; m1_data_i = $urandom;
      slv_set($urandom % 3 == 0, $urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
